// File: rtl/sqsum_serial_tx_if.sv
// -----------------------------------------------------------------------------
// sqsum_serial_tx_if
//
// Purpose:
//   Groups the sample-input and serial-output signals of sqsum_serial_tx so
//   the responder and whatever drives it share one bundle.
//
// Signals:
//   in_valid   1   sample qualifier; high for one frame's worth of beats
//   in_data    DW  unsigned sample, meaningful while in_valid=1
//   out_valid  1   result-bit qualifier
//   out_data   1   serial result bit, MSB first; 0 while out_valid=0
//
// Modports:
//   master  side that drives samples and receives the serial result
//   slave   the sqsum_serial_tx responder
// -----------------------------------------------------------------------------
interface sqsum_serial_tx_if #(
  parameter int DW = 4
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_data;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data
  );

endinterface : sqsum_serial_tx_if

// File: rtl/sqsum_serial_tx.sv
// -----------------------------------------------------------------------------
// sqsum_serial_tx
//
// Purpose:
//   Accepts a frame of N_IN unsigned DW-bit samples, accumulates the sum of
//   their squares into an OW-bit result and shifts that result out MSB-first
//   on a single serial bit qualified by out_valid.
//
//   Frame flow:  IDLE -> LOAD (remaining samples) -> CALC (1 cycle) ->
//                SEND (OW cycles) -> IDLE
//   If the last sample is seen in cycle T, CALC occupies T+1 and out_valid is
//   high from T+2 through T+OW+1. A new frame is accepted in T+OW+2.
//
// Ports:
//   clk   input   system clock, rising edge
//   rst   input   synchronous reset, active-high
//   bus   slave   sqsum_serial_tx_if: in_valid/in_data in,
//                 out_valid/out_data out (both outputs registered)
//
// Parameters:
//   N_IN  samples per frame
//   DW    sample width
//   OW    result width; results wrap mod 2**OW if it is too narrow for
//         N_IN*(2**DW-1)**2
// -----------------------------------------------------------------------------
module sqsum_serial_tx #(
  parameter int N_IN = 4,
  parameter int DW   = 4,
  parameter int OW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  sqsum_serial_tx_if.slave  bus
);

  // Sample counter must hold values up to N_IN; bit counter up to OW-1.
  localparam int CW = (N_IN > 1) ? $clog2(N_IN + 1) : 1;
  localparam int BW = (OW > 1)   ? $clog2(OW)       : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    SEND = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e          state_q,     state_d;
  logic [OW-1:0]   acc_q,       acc_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [OW-1:0]   shreg_q,     shreg_d;
  logic [BW-1:0]   bitcnt_q,    bitcnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_data_q,  out_data_d;

  // ---------------------------------------------------------------------------
  // Square of the incoming sample, resized to the accumulator width. The
  // product is evaluated at 2*DW bits so no square is ever truncated; the
  // resize only drops bits when OW is narrower than a single square, which
  // gives the intended mod-2**OW wrap.
  // ---------------------------------------------------------------------------
  logic [2*DW-1:0] sq;
  logic [OW-1:0]   sq_ext;

  assign sq     = bus.in_data * bus.in_data;
  assign sq_ext = OW'(sq);

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    out_valid_d = 1'b0;
    out_data_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = sq_ext;
          cnt_d   = CW'(1);
          state_d = (N_IN == 1) ? CALC : LOAD;
        end
      end

      LOAD: begin
        if (bus.in_valid) begin
          acc_d = acc_q + sq_ext;
          cnt_d = cnt_q + CW'(1);
          // cnt_q counts samples already taken, so N_IN-1 here means the
          // current beat completes the frame.
          if (cnt_q == CW'(N_IN - 1)) begin
            state_d = CALC;
          end
        end else begin
          // Short frame: drop the partial sum and produce no output.
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      CALC: begin
        // The MSB goes straight into the output register so out_valid rises
        // in the cycle after CALC; the shift register keeps the remaining
        // bits already aligned to its MSB. in_valid is ignored here.
        out_valid_d = 1'b1;
        out_data_d  = acc_q[OW-1];
        shreg_d     = acc_q << 1;
        bitcnt_d    = '0;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = SEND;
      end

      SEND: begin
        // bitcnt_q is the index (from the MSB) of the bit currently on
        // out_data; once the LSB has been presented the outputs drop to 0.
        if (bitcnt_q == BW'(OW - 1)) begin
          bitcnt_d = '0;
          state_d  = IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = shreg_q[OW-1];
          shreg_d     = shreg_q << 1;
          bitcnt_d    = bitcnt_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register update with synchronous reset. An in-flight frame or
  // transmission is abandoned as soon as rst is seen at an edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register here sample the
    // pre-edge values, so ordering of the statements does not matter.
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Outputs come straight from flops: no combinational input-to-output path.
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule : sqsum_serial_tx

// File: doc/sqsum_serial_tx.md
Name: sqsum_serial_tx

Overview:
Compute-and-serialize block on the DUT side of the 4-nibble-in / 10-bit-serial-out lab protocol. It accepts a frame of four 4-bit samples on in_valid/in_data and computes the sum of their squares. The 10-bit result is then shifted out MSB-first on a single-bit out_data, qualified by out_valid. It is the responder the team's PATTERN benches drive and check.

Parameters:
N_IN, 4, samples per frame
DW, 4, sample width in bits
OW, 10, result width in bits; must be >= ceil(log2(N_IN*(2^DW-1)^2 + 1)); defaults give max 900 < 1024

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  high for exactly N_IN consecutive cycles per frame
in_data  input  DW  unsigned sample, valid when in_valid=1
out_valid  output  1  high for exactly OW consecutive cycles per result
out_data  output  1  result bit, MSB first; 0 whenever out_valid=0

Behaviour:
- Interface: single clock domain, clk; reset is synchronous and active-high on port rst.
- Reset: when rst=1 at a rising edge:
  - state <= IDLE; accumulator, sample counter and bit counter <= 0
  - out_valid <= 0, out_data <= 0
  - Effective from that edge regardless of state; an in-flight frame or transmission is discarded.
- States:
  - IDLE:
    - in_valid=1 -> accumulate in_data^2 (acc <= in_data*in_data), cnt <= 1, go LOAD.
  - LOAD:
    - in_valid=1 -> acc <= acc + in_data^2, cnt <= cnt+1.
    - On the N_IN-th sample, go CALC.
    - in_valid=0 before N_IN samples -> short frame: discard acc, go IDLE, no output.
  - CALC:
    - One cycle; latch acc into the OW-bit shift register, go SEND.
  - SEND:
    - out_valid=1, out_data=shreg[OW-1], shift left each cycle, bit counter increments.
    - After OW cycles go IDLE; out_valid and out_data return to 0 in the next cycle.
- Registered outputs, no combinational path from inputs to outputs.
- Latency: the last in_valid cycle is cycle T. CALC occupies T+1. out_valid is first high in cycle T+2 and stays high through T+OW+1.
- Overlap rule: out_valid never high in a cycle with in_valid high. in_valid asserted during CALC/SEND is ignored (no accumulation, no state change); it is a protocol violation by the driver.
- Arithmetic: squares are unsigned DW*2 bits, accumulation is OW bits unsigned. With the default parameters no overflow is possible. If parameters violate the OW rule, the sum wraps mod 2^OW.
- Back-to-back frames: a new frame may start in the cycle after the last SEND cycle, i.e. when out_valid has just fallen. IDLE accepts it immediately.
- Extra in_valid beats: if in_valid stays high past N_IN beats, the beats arriving during CALC are ignored.

Test Plan:
- Reset: assert rst 2 cycles mid-SEND -> out_valid=0 and out_data=0 the cycle after the first rst edge; the next frame 1,1,1,1 -> output 0000000100 (=4).
- Frame 1,2,3,4 -> out_valid exactly 10 cycles starting 2 cycles after the last beat; out_data = 0000011110 (=30). out_valid=0 and out_data=0 the following cycle.
- Frame 15,15,15,15 -> 1110000100 (=900), the max value; checks width and no overflow.
- Frame 0,0,0,0 -> out_valid high 10 cycles with all-zero bits; the bench reads 0.
- Short frame: in_valid for 2 beats (5,5) then low -> no out_valid within 100 cycles. A subsequent full frame 3,0,0,4 -> 0000011001 (=25).
- Ten back-to-back random frames, each starting the cycle after out_valid falls -> every result equals the golden sum of squares; out_valid never overlaps in_valid; total latency equals 2 cycles per frame.
